// File: rtl/fp32_ctrl_pkg.sv
// Shared control types for the FP32 datapath sequencers.
// Pure declarations: no logic, no latency, no flow control.
package fp32_ctrl_pkg;

  localparam int CNT_WIDTH = 6;

  typedef enum logic [1:0] {
    CNT_IDLE = 2'd0,
    CNT_RUN  = 2'd1,
    CNT_DONE = 2'd2
  } cnt_state_t;

endpackage

// File: rtl/up_counter_6bit.sv
// Generic binary up-counter; clear has priority over enable, result visible one cycle later.
// No backpressure: the owner decides every cycle whether to clear, advance or hold.
module up_counter_6bit #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/iter_up_counter.sv
// Iteration sequencer: start -> busy next cycle, final en -> done pulse next cycle.
// en stalls the sequence indefinitely; abort cancels from any state without a done pulse.
module iter_up_counter
  import fp32_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             last,
  output logic             done
);

  cnt_state_t       state_q;
  cnt_state_t       state_d;
  logic [WIDTH-1:0] limit_q;
  logic             at_limit;
  logic             start_ok;
  logic             cnt_clr;
  logic             cnt_inc;

  assign at_limit = (count == limit_q);

  // start is only honoured outside RUN, and abort always wins over it
  assign start_ok = start && !abort && (state_q == CNT_IDLE || state_q == CNT_DONE);
  assign cnt_clr  = abort || start_ok;
  assign cnt_inc  = (state_q == CNT_RUN) && en && !at_limit && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CNT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit_q <= '0;
    end else if (start_ok) begin
      limit_q <= limit;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = CNT_IDLE;
    end else begin
      case (state_q)
        CNT_IDLE: if (start) state_d = CNT_RUN;
        CNT_RUN:  if (en && at_limit) state_d = CNT_DONE;
        CNT_DONE: state_d = start ? CNT_RUN : CNT_IDLE;
        default:  state_d = CNT_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    last = 1'b0;
    done = 1'b0;
    case (state_q)
      CNT_RUN: begin
        busy = 1'b1;
        last = at_limit;
      end
      CNT_DONE: done = 1'b1;
      default: ;
    endcase
  end

  up_counter_6bit #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_inc),
    .q     (count)
  );

endmodule

// File: tb/tb_iter_up_counter.sv
// Directed bench for iter_up_counter with hand-computed expectations.
module tb_iter_up_counter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] limit;
  logic       en;
  logic       abort;
  logic [5:0] count;
  logic       busy;
  logic       last;
  logic       done;

  int n_checks = 0;
  int n_fails  = 0;
  int busy_cycles;

  iter_up_counter #(.WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .limit (limit),
    .en    (en),
    .abort (abort),
    .count (count),
    .busy  (busy),
    .last  (last),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int c, input int b, input int l, input int d);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".busy"},  int'(busy),  b);
    chk({tag, ".last"},  int'(last),  l);
    chk({tag, ".done"},  int'(done),  d);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    limit = 6'd0;
    en    = 1'b0;
    abort = 1'b0;
    #12;
    chk_out("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk_out("idle_after_reset", 0, 0, 0, 0);

    // normal run, limit=3, en held high
    limit = 6'd3; start = 1'b1;
    tick();
    start = 1'b0; en = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("normal_i%0d", i), i, 1, (i == 3) ? 1 : 0, 0);
      if (busy) busy_cycles++;
      tick();
    end
    chk_out("normal_done", 3, 0, 0, 1);
    chk("normal_busy_cycles", busy_cycles, 4);
    en = 1'b0;
    tick();
    chk_out("normal_idle_hold", 3, 0, 0, 0);

    // stall pattern with limit change during RUN
    limit = 6'd2; start = 1'b1;
    tick();
    start = 1'b0; limit = 6'd9;
    en = 1'b1; chk_out("stall_s0", 0, 1, 0, 0); tick();
    en = 1'b0; chk_out("stall_s1", 1, 1, 0, 0); tick();
    en = 1'b0; chk_out("stall_s2", 1, 1, 0, 0); tick();
    en = 1'b1; chk_out("stall_s3", 1, 1, 0, 0); tick();
    en = 1'b1; chk_out("stall_s4", 2, 1, 1, 0); tick();
    en = 1'b0;
    chk_out("stall_done", 2, 0, 0, 1);
    tick();
    chk_out("stall_idle", 2, 0, 0, 0);

    // limit = 0
    limit = 6'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("lim0_first", 0, 1, 1, 0);
    tick();
    chk_out("lim0_stalled", 0, 1, 1, 0);
    en = 1'b1;
    tick();
    en = 1'b0;
    chk_out("lim0_done", 0, 0, 0, 1);
    tick();

    // limit = 63, full range without wrap
    limit = 6'd63; start = 1'b1;
    tick();
    start = 1'b0; en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("lim63_count_i%0d", i), int'(count), i);
      chk($sformatf("lim63_busy_i%0d", i), int'(busy), 1);
      tick();
    end
    en = 1'b0;
    chk_out("lim63_done", 63, 0, 0, 1);

    // back-to-back start accepted during DONE
    start = 1'b1; limit = 6'd1;
    tick();
    start = 1'b0;
    chk_out("b2b_run0", 0, 1, 0, 0);
    en = 1'b1;
    tick();
    chk_out("b2b_run1", 1, 1, 1, 0);
    tick();
    en = 1'b0;
    chk_out("b2b_done", 1, 0, 0, 1);
    tick();
    chk_out("b2b_idle", 1, 0, 0, 0);

    // abort at count=4 with en and start asserted
    limit = 6'd7; start = 1'b1;
    tick();
    start = 1'b0; en = 1'b1;
    repeat (4) tick();
    chk_out("abort_pre", 4, 1, 0, 0);
    abort = 1'b1; start = 1'b1; limit = 6'd5;
    tick();
    abort = 1'b0; start = 1'b0; en = 1'b0;
    chk_out("abort_idle", 0, 0, 0, 0);
    tick();
    chk_out("abort_no_start", 0, 0, 0, 0);

    // abort during DONE: pulse still seen, then count cleared
    limit = 6'd0; start = 1'b1;
    tick();
    start = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    chk_out("abort_done_pulse", 0, 0, 0, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_out("abort_done_idle", 0, 0, 0, 0);

    // async reset mid-RUN at count=5
    limit = 6'd10; start = 1'b1;
    tick();
    start = 1'b0; en = 1'b1;
    repeat (5) tick();
    chk_out("arst_pre", 5, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("arst_immediate", 0, 0, 0, 0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("arst_after", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
